// File: rtl/tile_color_sel.sv
// Tile-grid pixel colour selector: double-buffered palette, frame-synchronous
// display modes (tile / forced / blink / rotate), two-stage pixel pipeline.
module tile_color_sel #(
  parameter int COLOR_W      = 24,
  parameter int H_TILES      = 2,
  parameter int V_TILES      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int X_W          = 10,
  parameter int Y_W          = 10,
  parameter int BLINK_FRAMES = 30,
  localparam int N           = H_TILES * V_TILES,
  localparam int A_W         = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic               video_on,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic [A_W-1:0]     force_sel,
  input  logic               wr_en,
  input  logic [A_W-1:0]     wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic [COLOR_W-1:0] color,
  output logic               color_valid
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_TOP = FC_W'(BLINK_FRAMES - 1);
  localparam logic [A_W:0]    N_E    = (A_W + 1)'(N);
  localparam logic [A_W-1:0]  ROT_TOP = A_W'(N - 1);

  logic [COLOR_W-1:0] shadow [N];
  logic [COLOR_W-1:0] active [N];

  logic [1:0]      mode_r;
  logic [A_W-1:0]  force_r;
  logic [FC_W-1:0] fcnt_left;
  logic            phase;
  logic [A_W-1:0]  rot;
  logic [A_W-1:0]  rot_next;

  logic [A_W-1:0]  idx_c;
  logic [A_W-1:0]  idx_s1;
  logic            von_s1;

  logic            wr_ok;
  logic [A_W:0]    rsum;
  logic [A_W:0]    sel_e;
  logic [COLOR_W-1:0] color_c;

  // Column/row are threshold counts against compile-time boundaries; the
  // explicit clamp keeps out-of-range coordinates in the last column/row.
  always_comb begin
    int col_i;
    int row_i;
    col_i = 0;
    row_i = 0;
    for (int k = 1; k < H_TILES; k++)
      if (int'(x) >= (k * H_ACTIVE) / H_TILES) col_i++;
    for (int k = 1; k < V_TILES; k++)
      if (int'(y) >= (k * V_ACTIVE) / V_TILES) row_i++;
    if (int'(x) >= H_ACTIVE) col_i = H_TILES - 1;
    if (int'(y) >= V_ACTIVE) row_i = V_TILES - 1;
    idx_c = A_W'(row_i * H_TILES + col_i);
  end

  assign wr_ok = ({1'b0, wr_addr} < N_E);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en && wr_ok) shadow[wr_addr] <= wr_data;
      if (frame_start) begin
        for (int i = 0; i < N; i++) active[i] <= shadow[i];
        if (wr_en && wr_ok) active[wr_addr] <= wr_data;
      end
    end
  end

  assign rot_next = (rot == ROT_TOP) ? '0 : rot + A_W'(1);

  // fcnt_left counts down from BLINK_FRAMES-1; reaching zero is the step point.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r    <= 2'b00;
      force_r   <= '0;
      fcnt_left <= FC_TOP;
      phase     <= 1'b0;
      rot       <= '0;
    end else if (frame_start) begin
      mode_r  <= mode;
      force_r <= force_sel;
      if (mode != mode_r) begin
        fcnt_left <= FC_TOP;
        phase     <= 1'b0;
        rot       <= '0;
      end else if (fcnt_left == '0) begin
        fcnt_left <= FC_TOP;
        phase     <= ~phase;
        rot       <= rot_next;
      end else begin
        fcnt_left <= fcnt_left - FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_s1 <= '0;
      von_s1 <= 1'b0;
    end else begin
      idx_s1 <= idx_c;
      von_s1 <= video_on;
    end
  end

  always_comb begin
    rsum  = {1'b0, idx_s1} + {1'b0, rot};
    sel_e = {1'b0, idx_s1};
    case (mode_r)
      2'b01:   sel_e = ({1'b0, force_r} < N_E) ? {1'b0, force_r} : '0;
      2'b11:   sel_e = (rsum >= N_E) ? rsum - N_E : rsum;
      default: sel_e = {1'b0, idx_s1};
    endcase
    color_c = '0;
    for (int i = 0; i < N; i++)
      if (sel_e == (A_W + 1)'(i)) color_c = active[i];
    if (mode_r == 2'b10 && phase) color_c = '0;
    if (!von_s1) color_c = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color       <= '0;
      color_valid <= 1'b0;
    end else begin
      color       <= color_c;
      color_valid <= von_s1;
    end
  end

endmodule
